// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants and types for the data-memory responder.
//
// Contents:
//   - MMIO window base address and register offsets (TXDATA, STATUS, CYCLE, HALT)
//   - 2-bit register selects (ram_addr[3:2]) derived from those offsets
//   - uart_state_t: serializer states IDLE / START / DATA / STOP
//   - STATUS register bit positions
//   - merge_bytes(): applies 4-bit byte strobes to a 32-bit word
//
// No ports; imported by data_mem_responder and uart_tx_fifo.

package data_mem_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE  = 32'h0000_0008;
    localparam logic [31:0] OFF_HALT   = 32'h0000_000C;

    // Register select as seen on ram_addr[3:2] inside the MMIO window.
    localparam logic [1:0] REG_TXDATA = OFF_TXDATA[3:2];
    localparam logic [1:0] REG_STATUS = OFF_STATUS[3:2];
    localparam logic [1:0] REG_CYCLE  = OFF_CYCLE[3:2];
    localparam logic [1:0] REG_HALT   = OFF_HALT[3:2];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // STATUS = {28'b0, overflow, fifo_full, fifo_empty, tx_busy}
    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (aborts any frame in flight)
//   wr_en    in   enqueue request for wr_data
//   wr_data  in   [7:0] byte to enqueue
//   full     out  FIFO holds FIFO_DEPTH entries
//   empty    out  FIFO holds no entries
//   busy     out  serializer is not IDLE
//   deq      out  a byte leaves the FIFO at this clock edge
//   tx       out  serial line, idles high
//
// An enqueue while full is dropped unless a dequeue happens on the same
// edge; the parent watches wr_en/full/deq to maintain its overflow flag.

module uart_tx_fifo
    import data_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       deq,
    output logic       tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    uart_state_t      state_reg;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;

    logic bit_end;
    logic enq;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign busy    = (state_reg != IDLE);
    assign bit_end = (div_reg == DIV_W'(BAUD_DIV - 1));

    // Pull the next byte either from IDLE or straight out of the last stop
    // bit clock, so consecutive frames have no idle gap between them.
    assign deq = !empty && ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
    assign enq = wr_en && (!full || deq);

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    div_reg <= '0;
                    if (deq) begin
                        shift_reg <= fifo_mem[rd_ptr_reg];
                        state_reg <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        div_reg     <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_reg   <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        div_reg <= '0;
                        if (deq) begin
                            shift_reg <= fifo_mem[rd_ptr_reg];
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        div_reg <= div_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the core's data-memory interface.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   ram_r     in   core read enable
//   ram_w     in   [3:0] byte write strobes
//   ram_addr  in   [31:0] byte address (word aligned)
//   ram_out   in   [31:0] store data from core
//   ram_in    out  [31:0] load data to core (combinational, 0 when ram_r=0)
//   brk       in   core break indication
//   halted    out  sticky halt flag
//   uart_tx   out  8N1 serial output, idles high
//
// ram_addr[31]=0 selects the data RAM (word index ram_addr[ADDR_W+1:2],
// higher bits alias); ram_addr[31]=1 selects the MMIO registers by
// ram_addr[3:2]: TXDATA, STATUS, CYCLE, HALT.
//
// Build option: define CYCLE_COUNTER_EN to add the free-running 32-bit
// cycle counter at MMIO offset 0x8; otherwise that register reads 0.

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r,
    input  logic [3:0]  ram_w,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_out,
    output logic [31:0] ram_in,
    input  logic        brk,
    output logic        halted,
    output logic        uart_tx
);

    genvar gi;

    logic              is_mmio;
    logic [1:0]        reg_sel;
    logic [ADDR_W-1:0] word_idx;
    logic              store_en;
    logic              ram_we;
    logic              fifo_wr;
    logic              status_we;

    logic [31:0] ram_word;
    logic        halted_reg;
    logic        overflow_reg;

    logic fifo_full;
    logic fifo_empty;
    logic tx_busy;
    logic fifo_deq;

    // Address bits that neither the RAM nor the MMIO decode looks at.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_addr[30:ADDR_W+2], ram_addr[1:0]};

    assign is_mmio  = ram_addr[31];
    assign reg_sel  = ram_addr[3:2];
    assign word_idx = ram_addr[ADDR_W+1:2];

    // Once halted, every store is dropped, RAM and MMIO alike.
    assign store_en  = (|ram_w) && !halted_reg;
    assign ram_we    = store_en && !is_mmio;
    assign fifo_wr   = store_en && is_mmio && (reg_sel == REG_TXDATA) && ram_w[0];
    assign status_we = store_en && is_mmio && (reg_sel == REG_STATUS);

    // One RAM per byte lane keeps the byte strobes a plain per-lane write
    // enable; the read is asynchronous because the core expects the load
    // data in the same cycle it presents the address.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:(2**ADDR_W)-1];

            always_ff @(posedge clk) begin
                if (ram_we && ram_w[gi]) begin
                    lane_mem[word_idx] <= ram_out[8*gi +: 8];
                end
            end

            assign ram_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_reg <= 1'b0;
        end else if (brk) begin
            halted_reg <= 1'b1;
        end
    end

    // Overflow records an enqueue that found the FIFO full with no
    // dequeue on the same edge to make room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (status_we) begin
            overflow_reg <= 1'b0;
        end else if (fifo_wr && fifo_full && !fifo_deq) begin
            overflow_reg <= 1'b1;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic        cycle_we;
    logic [31:0] cycle_reg;
    logic [31:0] cycle_next;

    assign cycle_we = store_en && is_mmio && (reg_sel == REG_CYCLE);

    // A store takes priority over the increment on the same edge.
    always_comb begin
        cycle_next = cycle_reg;
        if (cycle_we) begin
            cycle_next = merge_bytes(cycle_reg, ram_out, ram_w);
        end else if (!halted_reg) begin
            cycle_next = cycle_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_next;
        end
    end
`endif

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV)
    ) u_uart_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (ram_out[7:0]),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .busy    (tx_busy),
        .deq     (fifo_deq),
        .tx      (uart_tx)
    );

    always_comb begin
        ram_in = '0;
        if (ram_r) begin
            if (!is_mmio) begin
                ram_in = ram_word;
            end else begin
                case (reg_sel)
                    REG_STATUS: begin
                        ram_in[STAT_BUSY]  = tx_busy;
                        ram_in[STAT_EMPTY] = fifo_empty;
                        ram_in[STAT_FULL]  = fifo_full;
                        ram_in[STAT_OVF]   = overflow_reg;
                    end
`ifdef CYCLE_COUNTER_EN
                    REG_CYCLE: ram_in = cycle_reg;
`endif
                    REG_HALT:  ram_in[0] = halted_reg;
                    default:   ram_in = '0;
                endcase
            end
        end
    end

    assign halted = halted_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder.
// A table of directed vectors, hand-written multi-cycle sequences and a
// randomized phase are all checked against a behavioural model that tracks
// RAM bytes, the TX queue, frame timing and the MMIO flags. A separate
// serial receiver decodes uart_tx into bytes.
// Honours CYCLE_COUNTER_EN the same way as the design.

module tb_data_mem_responder;

    localparam int B = 16;
    localparam int D = 8;
    localparam logic [31:0] TXD_A  = 32'h8000_0000;
    localparam logic [31:0] STAT_A = 32'h8000_0004;
    localparam logic [31:0] CYC_A  = 32'h8000_0008;
    localparam logic [31:0] HALT_A = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_r = 1'b0;
    logic [3:0]  ram_w = 4'h0;
    logic [31:0] ram_addr = 32'h0;
    logic [31:0] ram_out = 32'h0;
    logic [31:0] ram_in;
    logic        brk = 1'b0;
    logic        halted;
    logic        uart_tx;

    data_mem_responder #(.ADDR_W(10), .FIFO_DEPTH(D), .BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr),
        .ram_out(ram_out), .ram_in(ram_in), .brk(brk), .halted(halted), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m   [0:1023];
    bit   [3:0]  vmask_m [0:1023];
    logic [7:0]  q_m [$];
    longint      n_m;       // edges since reset
    longint      end_m;     // edge at which the current frame finishes
    logic [7:0]  cur_m;     // byte of the current frame
    bit          halted_m;
    bit          ovf_m;
    logic [31:0] cyc_m;

    logic [31:0] rd_sample;
    logic        tx_sample;

    function automatic void model_reset();
        q_m.delete();
        n_m = 0; end_m = 0; cur_m = 8'h0;
        halted_m = 0; ovf_m = 0; cyc_m = 32'h0;
    endfunction

    function automatic logic exp_tx();
        longint k;
        if (n_m >= end_m) return 1'b1;
        k = (n_m - (end_m - 10 * B)) / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur_m[k-1];
        return 1'b1;
    endfunction

    function automatic void model_read(input logic rr, input logic [31:0] a,
                                       output logic [31:0] v, output bit known);
        int idx;
        known = 1; v = 32'h0;
        if (!rr) return;
        if (!a[31]) begin
            idx = int'(a[11:2]);
            v = mem_m[idx];
            known = (vmask_m[idx] == 4'hF);
        end else begin
            case (a[3:2])
                2'd1: v = {28'h0, ovf_m, q_m.size() == D, q_m.size() == 0, n_m < end_m};
`ifdef CYCLE_COUNTER_EN
                2'd2: v = cyc_m;
`endif
                2'd3: v = {31'h0, halted_m};
                default: v = 32'h0;
            endcase
        end
    endfunction

    function automatic void model_edge(input logic rs, input logic [3:0] w, input logic [31:0] a,
                                       input logic [31:0] d, input logic b);
        longint e;
        bit deq, full_pre, cyc_wr;
        int idx;
        if (rs) begin
            model_reset();
            return;
        end
        e = n_m + 1;
        full_pre = (q_m.size() == D);
        deq = (q_m.size() > 0) && (e >= end_m);
        if (deq) begin
            cur_m = q_m.pop_front();
            end_m = e + 10 * B;
        end
        cyc_wr = 0;
        if (w != 4'h0 && !halted_m) begin
            if (!a[31]) begin
                idx = int'(a[11:2]);
                for (int i = 0; i < 4; i++)
                    if (w[i]) begin
                        mem_m[idx][8*i +: 8] = d[8*i +: 8];
                        vmask_m[idx][i] = 1'b1;
                    end
            end else begin
                case (a[3:2])
                    2'd0: if (w[0]) begin
                        if (!full_pre || deq) q_m.push_back(d[7:0]);
                        else ovf_m = 1;
                    end
                    2'd1: ovf_m = 0;
                    2'd2: begin
`ifdef CYCLE_COUNTER_EN
                        cyc_wr = 1;
                        for (int i = 0; i < 4; i++)
                            if (w[i]) cyc_m[8*i +: 8] = d[8*i +: 8];
`endif
                    end
                    default: ;
                endcase
            end
        end
        if (!cyc_wr && !halted_m) cyc_m = cyc_m + 32'd1;
        if (b) halted_m = 1;
        n_m = e;
    endfunction

    // ---------------- serial receiver ----------------
    logic [7:0] rx_q [$];
    int  rx_ferr = 0;
    bit  rx_act = 0;
    int  rx_cnt = 0;
    logic [7:0] rx_sh = 8'h0;

    always @(negedge clk) begin
        int k;
        #2;
        if (rst) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin rx_act = 1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % B == B / 2) begin
                k = rx_cnt / B;
                if (k == 0) begin
                    if (uart_tx !== 1'b0) rx_act = 0;
                end else if (k <= 8) begin
                    rx_sh[k-1] = uart_tx;
                end else begin
                    if (uart_tx !== 1'b1) rx_ferr++;
                    rx_q.push_back(rx_sh);
                    rx_act = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rr, input logic [3:0] ww, input logic [31:0] aa,
                        input logic [31:0] dd, input logic bb, input logic rs);
        logic [31:0] ev;
        bit known;
        @(negedge clk);
        rst = rs; ram_r = rr; ram_w = ww; ram_addr = aa; ram_out = dd; brk = bb;
        #1;
        rd_sample = ram_in;
        tx_sample = uart_tx;
        model_read(rr, aa, ev, known);
        if (known) check("model_ram_in", ram_in, ev);
        check("model_uart_tx", {31'h0, uart_tx}, {31'h0, exp_tx()});
        check("model_halted", {31'h0, halted}, {31'h0, halted_m});
        @(posedge clk);
        model_edge(rs, ww, aa, dd, bb);
    endtask

    task automatic idle();
        step(1'b1, 4'h0, STAT_A, 32'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [7:0]  b55;
        logic [31:0] a;
        logic        expb;
        int          k, op;

        model_reset();
        repeat (2) @(posedge clk);

        // ---- table-driven vectors: RAM strobes, aliasing, MMIO reset values ----
        tbl[0]  = '{1'b0, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b0, 4'h1, 32'h0000_0040, 32'h0000_00AA, 32'h0};
        tbl[2]  = '{1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEAA};
        tbl[3]  = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 4'h0, 32'h0000_1040, 32'h0,         32'hDEAD_BEAA};
        tbl[5]  = '{1'b0, 4'hF, 32'h0000_0044, 32'h0,         32'h0};
        tbl[6]  = '{1'b1, 4'hC, 32'h0000_0044, 32'h1234_5678, 32'h0};
        tbl[7]  = '{1'b1, 4'h0, 32'h7FF0_0044, 32'h0,         32'h1234_0000};
        tbl[8]  = '{1'b1, 4'h0, STAT_A,        32'h0,         32'h2};
        tbl[9]  = '{1'b1, 4'h0, HALT_A,        32'h0,         32'h0};
        tbl[10] = '{1'b1, 4'h0, TXD_A,         32'h0,         32'h0};
        tbl[11] = '{1'b0, 4'hF, HALT_A,        32'h1,         32'h0};
        tbl[12] = '{1'b1, 4'h0, HALT_A,        32'h0,         32'h0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b0);
            check($sformatf("vec%0d_ram_in", i), rd_sample, tbl[i].exp);
            $display("vec %0d: r=%0b w=%h addr=%08h ram_in=%08h", i, tbl[i].r, tbl[i].w, tbl[i].a, rd_sample);
        end

        // ---- single 0x55 frame, exact waveform ----
        b55 = 8'h55;
        step(1'b0, 4'h1, TXD_A, 32'h55, 1'b0, 1'b0);
        idle();
        check("frame_pre_tx", {31'h0, tx_sample}, 32'h1);
        check("frame_pre_status", rd_sample, 32'h0);
        for (int c = 0; c < 10 * B; c++) begin
            idle();
            k = c / B;
            expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b55[k-1];
            check($sformatf("frame55_bit%0d", k), {31'h0, tx_sample}, {31'h0, expb});
            check("frame55_busy", {31'h0, rd_sample[0]}, 32'h1);
        end
        idle();
        check("frame_post_tx", {31'h0, tx_sample}, 32'h1);
        check("frame_post_status", rd_sample, 32'h2);
        $display("frame 0x55 waveform walked, %0d cycles", 10 * B);

        // ---- FIFO fill and overflow ----
        rx_q.delete();
        for (int i = 0; i < D + 2; i++) step(1'b0, 4'h1, TXD_A, 32'h30 + i, 1'b0, 1'b0);
        idle();
        check("fifo_status_full_ovf", rd_sample, 32'hD);
        step(1'b0, 4'hF, STAT_A, 32'h0, 1'b0, 1'b0);
        idle();
        check("fifo_status_ovf_clr", rd_sample, 32'h5);
        for (int c = 0; c < 12 * B * (D + 2) && rx_q.size() < D + 1; c++) idle();
        repeat (12 * B) idle();
        check("fifo_frame_count", rx_q.size(), D + 1);
        for (int i = 0; i < D + 1 && i < rx_q.size(); i++) begin
            check($sformatf("fifo_frame%0d", i), {24'h0, rx_q[i]}, 32'h30 + i);
            $display("fifo frame %0d: byte %02h", i, rx_q[i]);
        end
        check("fifo_framing", rx_ferr, 0);
        check("fifo_drained_status", rd_sample, 32'h2);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 16; i++) step(1'b0, 4'hF, 32'h100 + 4 * i, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            op = $urandom_range(0, 9);
            a = {1'b0, 19'($urandom), 10'(64 + $urandom_range(0, 15)), 2'b00};
            case (op)
                0, 1, 2: step(1'($urandom), 4'($urandom_range(1, 15)), a, $urandom, 1'b0, 1'b0);
                3, 4:    step(1'b1, 4'h0, a, 32'h0, 1'b0, 1'b0);
                5:       step(1'b1, 4'h0, STAT_A, 32'h0, 1'b0, 1'b0);
                6:       step(1'($urandom), 4'($urandom), TXD_A, $urandom, 1'b0, 1'b0);
                7:       step(1'($urandom), 4'($urandom_range(1, 15)),
                              {28'h8000_000, 2'($urandom_range(1, 3)), 2'b00}, $urandom, 1'b0, 1'b0);
                8:       step(1'b1, 4'h0, {28'h8000_000, 2'($urandom), 2'b00}, 32'h0, 1'b0, 1'b0);
                default: step(1'b1, 4'h0, CYC_A, 32'h0, 1'b0, 1'b0);
            endcase
        end
        $display("random phase: 500 transactions, %0d compared so far", n_cmp);

        // ---- reset in the middle of a frame ----
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 4'hF, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b0);
        step(1'b0, 4'h1, TXD_A, 32'hA5, 1'b0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3 * B) idle();
        check("pre_reset_busy", {31'h0, rd_sample[0]}, 32'h1);
        check("pre_reset_halted", {31'h0, halted}, 32'h1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();
        check("reset_tx", {31'h0, tx_sample}, 32'h1);
        check("reset_status", rd_sample, 32'h2);
        check("reset_halted", {31'h0, halted}, 32'h0);
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b0);
        check("reset_ram_kept", rd_sample, 32'hCAFE_F00D);
        $display("reset mid-frame: uart_tx=%0b halted=%0b ram[0x40]=%08h", tx_sample, halted, rd_sample);

        // ---- cycle counter wrap ----
        step(1'b0, 4'hF, CYC_A, 32'hFFFF_FFFE, 1'b0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 4'h0, CYC_A, 32'h0, 1'b0, 1'b0);
        check("cycle_wrap", rd_sample, 32'h0);
        $display("cycle register after wrap: %08h", rd_sample);

        // ---- halt: stores ignored, UART drains ----
        rx_q.delete();
        step(1'b0, 4'hF, 32'h40, 32'h1122_3344, 1'b0, 1'b0);
        step(1'b0, 4'h1, TXD_A, 32'h3C, 1'b0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 4'h0, HALT_A, 32'h0, 1'b0, 1'b0);
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_reg", rd_sample, 32'h1);
        step(1'b0, 4'hF, 32'h40, 32'h9999_9999, 1'b0, 1'b0);
        step(1'b0, 4'h1, TXD_A, 32'h77, 1'b0, 1'b0);
        step(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b0);
        check("halt_store_ignored", rd_sample, 32'h1122_3344);
        for (int c = 0; c < 12 * B && rx_q.size() < 1; c++) idle();
        repeat (12 * B) idle();
        check("halt_drain_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("halt_drain_byte", {24'h0, rx_q[0]}, 32'h3C);
        $display("halt: halted=%0b frames after halt=%0d", halted, rx_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
